reg_bank_ce2: RTL

REG_BANK_CE2 -- requirements
Module: reg_bank_ce2

---
 rtl/reg_bank_ce2_pkg.sv | 7 +
 rtl/reg_bank_ce2_cell.sv | 36 +++
 rtl/reg_bank_ce2.sv | 96 +++++++++
 3 files changed

// File: rtl/reg_bank_ce2_pkg.sv
// reg_bank_ce2_pkg: FSM state type and default parameters shared by the shadow register bank.
package reg_bank_ce2_pkg;
   typedef enum logic {IDLE, WAIT_SAFE} state_t;
   localparam int DEF_WIDTH          = 32;
   localparam int DEF_DEPTH          = 8;
   localparam int DEF_TIMEOUT_CYCLES = 65535;
endpackage

// File: rtl/reg_bank_ce2_cell.sv
// reg_shadow_cell: one shadow/active register pair with its dirty flag; reset and soft reset load the default.
module reg_shadow_cell #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] def_value,
   input  logic             soft_reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             commit,
   output logic [WIDTH-1:0] active,
   output logic             pending
);
   logic [WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
   logic             pending_q, pending_d;
   always_comb begin
      shadow_d  = soft_reset ? def_value : wr_en ? wr_data : shadow_q;
      active_d  = soft_reset ? def_value : (commit && pending_q) ? shadow_q : active_q;
      // a write on the commit edge keeps the flag set so the new value goes out next commit
      pending_d = soft_reset ? 1'b0 : wr_en ? 1'b1 : commit ? 1'b0 : pending_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q  <= def_value;
         active_q  <= def_value;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end
   assign active  = active_q;
   assign pending = pending_q;
endmodule

// File: rtl/reg_bank_ce2.sv
// reg_bank_ce2: shadowed register bank with a safe-boundary commit handshake.
// Define REG_BANK_TIMEOUT_EN to abort commits that wait TIMEOUT_CYCLES without a safe boundary.
module reg_bank_ce2
   import reg_bank_ce2_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [DEPTH*WIDTH-1:0] def_value,
   input  logic                   soft_reset,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   clk_en1,
   input  logic                   clk_en2,
   input  logic                   commit_req,
   input  logic                   safe,
   output logic [DEPTH*WIDTH-1:0] out,
   output logic [DEPTH-1:0]       pending,
   output logic                   busy,
   output logic                   commit_ack,
   output logic                   timeout_err
);
   if (DEPTH < 2 || DEPTH > 256 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("reg_bank_ce2: DEPTH must be 2..256 and TIMEOUT_CYCLES at least 1");
   end
   state_t state_q, state_d;
   logic   ack_q, ack_d, commit, wr_ok;
   assign commit = (state_q == WAIT_SAFE) && safe && !soft_reset;
   assign wr_ok  = clk_en1 && clk_en2 && !soft_reset;
`ifdef REG_BANK_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d, expire;
   assign expire = (state_q == WAIT_SAFE) && !safe && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      if (soft_reset) state_d = IDLE;
      else if (state_q == IDLE) state_d = commit_req ? WAIT_SAFE : IDLE;
      else if (safe) begin
         state_d = IDLE;
         ack_d   = 1'b1;
      end
`ifdef REG_BANK_TIMEOUT_EN
      else if (expire) state_d = IDLE;
`endif
   end
`ifdef REG_BANK_TIMEOUT_EN
   always_comb begin
      cnt_d = (state_q == WAIT_SAFE && state_d == WAIT_SAFE) ? cnt_q + 1'b1 : '0;
      err_d = (soft_reset || (state_q == IDLE && commit_req)) ? 1'b0 : (expire || err_q);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end
   assign busy       = (state_q == WAIT_SAFE);
   assign commit_ack = ack_q;
   // addresses at or beyond DEPTH match no cell, so they are dropped
   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      reg_shadow_cell #(.WIDTH(WIDTH)) u_cell (
         .clk       (clk),
         .reset_n   (reset_n),
         .def_value (def_value[i*WIDTH +: WIDTH]),
         .soft_reset(soft_reset),
         .wr_en     (wr_ok && (wr_addr == ADDR_W'(i))),
         .wr_data   (wr_data),
         .commit    (commit),
         .active    (out[i*WIDTH +: WIDTH]),
         .pending   (pending[i])
      );
   end
endmodule
